// File: rtl/analog_scan_ctrl.sv
// Wishbone-programmable analog mux scan sequencer. It settles on each masked channel in turn,
// strobes the converter, captures its 8-bit result and raises a level interrupt when the scan is done.
module analog_scan_ctrl #(
  parameter int          NUM_CH   = 8,
  parameter int          SETTLE_W = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  mux_sel_o,
  output logic        mux_en_o,
  output logic        sample_o,
  input  logic [7:0]  sample_data_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_SAMPLE, S_NEXT} state_e;

  state_e              state_q;
  logic [2:0]          ch_q, mux_sel_q;
  logic [SETTLE_W-1:0] cnt_q, settle_q, settle_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                mux_en_q, sample_q, done_q, cont_q, ack_q;
  logic [31:0]         dat_q, rdata, be, wdat;
  logic [7:0]          result_q [NUM_CH];

  logic       req, hit, wr, ctrl_wr, start_w, irq_clr_w, abort_w, busy;
  logic [5:0] word, res_w;
  logic [2:0] lowest_ch, above_ch;
  logic       above_found;

  function automatic logic [2:0] lowest(input logic [NUM_CH-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) r = i[2:0];
    return r;
  endfunction

  function automatic logic [3:0] next_above(input logic [NUM_CH-1:0] m, input logic [2:0] c);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i] && i > int'(c)) r = {1'b1, i[2:0]};
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_be
      assign be[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign hit       = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign word      = wbs_adr_i[7:2];
  assign res_w     = word - 6'd4;
  assign wr        = req & wbs_we_i & hit;
  assign wdat      = wbs_dat_i & be;
  assign ctrl_wr   = wr && (word == 6'd0) && wbs_sel_i[0];
  assign start_w   = ctrl_wr & wbs_dat_i[0];
  assign irq_clr_w = ctrl_wr & wbs_dat_i[2];
  assign abort_w   = ctrl_wr & wbs_dat_i[3];
  assign busy      = (state_q != S_IDLE);
  assign mask_d    = (mask_q & ~be[NUM_CH-1:0]) | wdat[NUM_CH-1:0];
  assign settle_d  = (settle_q & ~be[SETTLE_W-1:0]) | wdat[SETTLE_W-1:0];
  assign lowest_ch = lowest(mask_q);
  assign {above_found, above_ch} = next_above(mask_q, ch_q);

  always_comb begin
    rdata = '0;
    if (hit) begin
      if (word == 6'd0) rdata[1] = cont_q;
      else if (word == 6'd1) rdata[NUM_CH-1:0] = mask_q;
      else if (word == 6'd2) rdata[SETTLE_W-1:0] = settle_q;
      else if (word == 6'd3) begin
        rdata[0]    = busy;
        rdata[1]    = done_q;
        rdata[10:8] = ch_q;
      end else if (word >= 6'd4 && {26'b0, res_w} < NUM_CH) rdata[7:0] = result_q[res_w[2:0]];
    end
  end

  // Bus side: MASK and SETTLE are frozen while a scan runs, so the FSM can use mask_q directly.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      cont_q   <= 1'b0;
      mask_q   <= '0;
      settle_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= req ? rdata : 32'h0;
      if (ctrl_wr) cont_q <= wbs_dat_i[1];
      if (wr && !busy && word == 6'd1) mask_q <= mask_d;
      if (wr && !busy && word == 6'd2) settle_q <= settle_d;
    end
  end

  // Outputs are registered and loaded on the transition into the state that asserts them.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      cnt_q     <= '0;
      mux_sel_q <= '0;
      mux_en_q  <= 1'b0;
      sample_q  <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
    end else begin
      sample_q <= 1'b0;
      if (irq_clr_w) done_q <= 1'b0;
      if (state_q == S_SAMPLE) result_q[ch_q] <= sample_data_i;
      if (abort_w) begin
        state_q  <= S_IDLE;
        mux_en_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start_w) begin
            if (mask_q != '0) begin
              ch_q      <= lowest_ch;
              mux_sel_q <= lowest_ch;
              mux_en_q  <= 1'b1;
              state_q   <= S_SELECT;
            end else begin
              done_q <= 1'b1;
            end
          end
          S_SELECT: begin
            cnt_q   <= settle_q;
            state_q <= S_SETTLE;
          end
          S_SETTLE: begin
            if (cnt_q == '0) begin
              state_q  <= S_SAMPLE;
              sample_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - SETTLE_W'(1);
            end
          end
          S_SAMPLE: state_q <= S_NEXT;
          S_NEXT: begin
            if (above_found) begin
              ch_q      <= above_ch;
              mux_sel_q <= above_ch;
              state_q   <= S_SELECT;
            end else if (cont_q) begin
              ch_q      <= lowest_ch;
              mux_sel_q <= lowest_ch;
              state_q   <= S_SELECT;
            end else begin
              state_q  <= S_IDLE;
              mux_en_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wdat};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign mux_sel_o = mux_sel_q;
  assign mux_en_o  = mux_en_q;
  assign sample_o  = sample_q;
  assign irq_o     = done_q;

endmodule

// File: tb/tb_analog_scan_ctrl.sv
// Directed bench for analog_scan_ctrl: scan timing, continuous mode, abort, empty mask,
// interrupt clear/set race, Wishbone handshake and byte lanes, and reset mid-scan.
module tb_analog_scan_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00, A_MASK = BASE + 32'h04;
  localparam logic [31:0] A_SETTLE = BASE + 32'h08, A_STATUS = BASE + 32'h0C;

  logic        clk = 1'b0, rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [2:0]  mux_sel;
  logic        mux_en, sample, irq;
  logic [7:0]  sdata = 8'h00;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  analog_scan_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .mux_sel_o(mux_sel), .mux_en_o(mux_en), .sample_o(sample), .sample_data_i(sdata), .irq_o(irq)
  );

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = a; wdat = d; sel = s;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    checks++;
    if (!ack) begin errors++; $display("FAIL wb_write_ack adr=%h got ack=0 exp ack=1", a); end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    checks++;
    if (!ack) begin errors++; $display("FAIL wb_read_ack adr=%h got ack=0 exp ack=1", a); end
    d = rdat;
    cyc = 0; stb = 0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1; repeat (2) @(posedge clk); #1; rst = 0;
    checks++;
    if ({mux_en, irq, sample} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got en/irq/smp=%b exp 000", {mux_en, irq, sample});
    end
    for (int k = 0; k < 12; k++) begin
      wb_read(BASE + 32'(k * 4), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_reg off=%h got %h exp 0", k * 4, d); end
    end
    $display("reset: outputs and 12 registers checked");
  endtask

  task automatic test_scan;
    logic [31:0] d;
    logic [2:0]  exp_sel;
    wb_write(A_MASK, 32'h05, 4'hF);
    wb_write(A_SETTLE, 32'd3, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    for (int c = 0; c <= 14; c++) begin
      exp_sel = (c < 7) ? 3'd0 : 3'd2;
      checks++;
      if (sample !== (c == 5 || c == 12) || mux_en !== (c < 14) || mux_sel !== exp_sel || irq !== (c == 14)) begin
        errors++;
        $display("FAIL scan_cycle c=%0d got smp=%b en=%b sel=%0d irq=%b exp smp=%b en=%b sel=%0d irq=%b",
                 c, sample, mux_en, mux_sel, irq, (c == 5 || c == 12), (c < 14), exp_sel, (c == 14));
      end
      sdata = (c < 7) ? 8'hA5 : 8'h3C;
      @(posedge clk); #1;
    end
    wb_read(BASE + 32'h10, d);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL scan_result0 got %h exp a5", d); end
    wb_read(BASE + 32'h14, d);
    checks++; if (d !== 32'h00) begin errors++; $display("FAIL scan_result1 got %h exp 0", d); end
    wb_read(BASE + 32'h18, d);
    checks++; if (d !== 32'h3C) begin errors++; $display("FAIL scan_result2 got %h exp 3c", d); end
    wb_read(A_STATUS, d);
    checks++; if (d !== 32'h202) begin errors++; $display("FAIL scan_status got %h exp 202", d); end
    $display("scan: mask 05 settle 3 two-channel pass checked");
  endtask

  task automatic test_cont;
    logic [31:0] d;
    int nsamp = 0, n = 0;
    wb_write(A_CTRL, 32'h4, 4'hF);
    wb_write(A_MASK, 32'h80, 4'hF);
    wb_write(A_SETTLE, 32'd0, 4'hF);
    sdata = 8'h11;
    wb_write(A_CTRL, 32'h3, 4'hF);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (sample !== ((c % 4) == 2) || mux_sel !== 3'd7 || mux_en !== 1'b1) begin
        errors++;
        $display("FAIL cont_cycle c=%0d got smp=%b sel=%0d en=%b exp smp=%b sel=7 en=1",
                 c, sample, mux_sel, mux_en, ((c % 4) == 2));
      end
      @(posedge clk); #1;
    end
    wb_write(A_CTRL, 32'h0, 4'hF);
    while (mux_en && n < 40) begin
      if (sample) nsamp++;
      @(posedge clk); #1; n++;
    end
    checks++; if (mux_en !== 1'b0) begin errors++; $display("FAIL cont_stop_timeout got en=1 exp en=0"); end
    checks++; if (nsamp != 1) begin errors++; $display("FAIL cont_tail_samples got %0d exp 1", nsamp); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cont_irq got %b exp 1", irq); end
    wb_read(A_STATUS, d);
    checks++; if (d !== 32'h702) begin errors++; $display("FAIL cont_status got %h exp 702", d); end
    wb_read(BASE + 32'h2C, d);
    checks++; if (d !== 32'h11) begin errors++; $display("FAIL cont_result7 got %h exp 11", d); end
    $display("cont: ch7 period 4 and single tail sample checked");
  endtask

  task automatic test_abort;
    logic [31:0] d;
    int nsamp = 0;
    wb_write(A_CTRL, 32'h4, 4'hF);
    wb_write(A_MASK, 32'h01, 4'hF);
    wb_write(A_SETTLE, 32'd20, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    repeat (2) @(posedge clk); #1;
    wb_write(A_MASK, 32'hFF, 4'hF);
    wb_write(A_SETTLE, 32'd5, 4'hF);
    wb_write(A_CTRL, 32'h8, 4'hF);
    checks++;
    if ({mux_en, sample} !== 2'b00) begin
      errors++; $display("FAIL abort_outputs got en/smp=%b exp 00", {mux_en, sample});
    end
    for (int c = 0; c < 30; c++) begin
      if (sample) nsamp++;
      @(posedge clk); #1;
    end
    checks++; if (nsamp != 0) begin errors++; $display("FAIL abort_no_sample got %0d exp 0", nsamp); end
    wb_read(A_STATUS, d);
    checks++; if (d !== 32'h000) begin errors++; $display("FAIL abort_status got %h exp 0", d); end
    wb_read(A_MASK, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL abort_mask_frozen got %h exp 01", d); end
    wb_read(A_SETTLE, d);
    checks++; if (d !== 32'd20) begin errors++; $display("FAIL abort_settle_frozen got %h exp 14", d); end
    $display("abort: idle after abort, registers frozen during scan");
  endtask

  task automatic test_mask_zero;
    logic [31:0] d;
    wb_write(A_MASK, 32'h00, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    checks++;
    if ({irq, mux_en} !== 2'b10) begin
      errors++; $display("FAIL mask0_outputs got irq/en=%b exp 10", {irq, mux_en});
    end
    wb_read(A_STATUS, d);
    checks++; if (d !== 32'h002) begin errors++; $display("FAIL mask0_status got %h exp 002", d); end
    wb_write(A_CTRL, 32'h4, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
    wb_write(A_MASK, 32'h01, 4'hF);
    wb_write(A_SETTLE, 32'd0, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    repeat (2) @(posedge clk); #1;
    wb_write(A_CTRL, 32'h4, 4'hF);
    checks++;
    if ({irq, mux_en} !== 2'b10) begin
      errors++; $display("FAIL irq_set_wins got irq/en=%b exp 10", {irq, mux_en});
    end
    $display("mask0: empty scan and set-over-clear race checked");
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic        exp_ack = 1'b1;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = A_SETTLE; sel = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== exp_ack) begin errors++; $display("FAIL b2b_ack c=%0d got %b exp %b", c, ack, exp_ack); end
      exp_ack = ~exp_ack;
    end
    cyc = 0; stb = 0;
    wb_write(A_SETTLE, 32'h0000_1234, 4'hF);
    wb_write(A_SETTLE, 32'h0000_56AB, 4'b0001);
    wb_read(A_SETTLE, d);
    checks++; if (d !== 32'h12AB) begin errors++; $display("FAIL byte_lane got %h exp 12ab", d); end
    wb_write(BASE + 32'h80, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'h80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", d); end
    wb_read(32'h3000_0108, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL off_base_read got %h exp 0", d); end
    $display("wishbone: ack pattern, byte lanes, unmapped reads checked");
  endtask

  task automatic test_reset_mid_scan;
    logic [31:0] d;
    wb_write(A_MASK, 32'h01, 4'hF);
    wb_write(A_SETTLE, 32'd2, 4'hF);
    sdata = 8'h77;
    wb_write(A_CTRL, 32'h3, 4'hF);
    repeat (5) @(posedge clk); #1;
    rst = 1; @(posedge clk); #1; rst = 0;
    checks++;
    if ({mux_en, irq, sample} !== 3'b000 || mux_sel !== 3'd0) begin
      errors++; $display("FAIL midrst_outputs got en/irq/smp=%b sel=%0d exp 000 sel=0", {mux_en, irq, sample}, mux_sel);
    end
    wb_read(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_result0 got %h exp 0", d); end
    wb_read(A_STATUS, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_status got %h exp 0", d); end
    wb_read(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_ctrl got %h exp 0", d); end
    $display("reset mid-scan: state cleared");
  endtask

  initial begin
    test_reset;
    test_scan;
    test_cont;
    test_abort;
    test_mask_zero;
    test_back_to_back;
    test_reset_mid_scan;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
